pc_alu_datapath: RTL and testbench

- Combines the core's program-counter register (ProgramCounter function) and its combinational arithmetic/logic unit (ALU function) in one datapath slice.
- The two halves share only the clock domain. The ALU computes results and a zero flag from two operands.
- The PC register loads a new address when enabled.
- PC increment is performed by routing PC_OUT into SRCA, a constant 2 into SRCB with ALUOP=ADD, and ALU_OUT back into PC_IN. This routing is done by the enclosing datapath.

---
 rtl/pc_alu_datapath.sv | 138 +++++++++++++
 tb/tb_pc_alu_datapath.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_alu_datapath.sv
// pc_alu_datapath: one datapath slice holding the program-counter register
// and the combinational ALU. The halves share only the clock; the enclosing
// datapath does the PC+2 routing (PC_OUT -> SRCA, 2 -> SRCB, ADD, ALU_OUT -> PC_IN).
module pc_alu_datapath #(
  parameter int unsigned          WIDTH        = 16,
  parameter logic [WIDTH-1:0]     PC_RESET_VAL = '0
) (
  input  logic             CLOCK,
  input  logic             PC_RESET,
  input  logic             PC_EN,
  input  logic [WIDTH-1:0] PC_IN,
  output logic [WIDTH-1:0] PC_OUT,
  input  logic [WIDTH-1:0] SRCA,
  input  logic [WIDTH-1:0] SRCB,
  input  logic [3:0]       ALUOP,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             ALU_ZERO,
  output logic             ALU_OVF
);

  // Opcode encoding; 1101..1111 are unassigned and produce a zero result.
  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_NOR   = 4'b0101,
    OP_SLL   = 4'b0110,
    OP_SRL   = 4'b0111,
    OP_SRA   = 4'b1000,
    OP_SLT   = 4'b1001,
    OP_SLTU  = 4'b1010,
    OP_PASSA = 4'b1011,
    OP_PASSB = 4'b1100
  } alu_op_e;

  localparam int unsigned MSB = WIDTH - 1;

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------

  logic [WIDTH-1:0] pc_q;

  // PC register: synchronous reset wins over the load enable, otherwise hold.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge CLOCK) begin
    if (PC_RESET) begin
      pc_q <= PC_RESET_VAL;
    end else if (PC_EN) begin
      pc_q <= PC_IN;
    end
  end

  assign PC_OUT = pc_q;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------

  alu_op_e          op;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic [3:0]       shamt;
  logic [WIDTH-1:0] sll_res;
  logic [WIDTH-1:0] srl_res;
  logic [WIDTH-1:0] sra_res;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] result;
  logic             ovf;

  assign op = alu_op_e'(ALUOP);

  // Adder and subtractor; carry/borrow out is dropped, only signed overflow kept.
  always_comb begin
    sum     = SRCA + SRCB;
    diff    = SRCA - SRCB;
    // Same-sign operands whose sum flips sign.
    add_ovf = (SRCA[MSB] == SRCB[MSB]) && (sum[MSB] != SRCA[MSB]);
    // Opposite-sign operands whose difference disagrees with A's sign.
    sub_ovf = (SRCA[MSB] != SRCB[MSB]) && (diff[MSB] != SRCA[MSB]);
  end

  // Barrel shifts; only B[3:0] selects the distance, upper B bits are ignored.
  always_comb begin
    shamt   = SRCB[3:0];
    sll_res = SRCA << shamt;
    srl_res = SRCA >> shamt;
    sra_res = WIDTH'($signed(SRCA) >>> shamt);
  end

  // Set-less-than comparators, signed and unsigned.
  always_comb begin
    lt_signed   = $signed(SRCA) < $signed(SRCB);
    lt_unsigned = SRCA < SRCB;
  end

  // Result select and overflow flag by opcode.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    unique case (op)
      OP_ADD: begin
        result = sum;
        ovf    = add_ovf;
      end
      OP_SUB: begin
        result = diff;
        ovf    = sub_ovf;
      end
      OP_AND:   result = SRCA & SRCB;
      OP_OR:    result = SRCA | SRCB;
      OP_XOR:   result = SRCA ^ SRCB;
      OP_NOR:   result = ~(SRCA | SRCB);
      OP_SLL:   result = sll_res;
      OP_SRL:   result = srl_res;
      OP_SRA:   result = sra_res;
      OP_SLT:   result = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU:  result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_PASSA: result = SRCA;
      OP_PASSB: result = SRCB;
      default:  result = '0;
    endcase
  end

  assign ALU_OUT  = result;
  assign ALU_OVF  = ovf;
  // Zero flag follows the result for every opcode, undefined ones included.
  assign ALU_ZERO = (result == '0);

endmodule

// File: tb/tb_pc_alu_datapath.sv
// tb_pc_alu_datapath: directed plus randomized checks of the PC register and
// ALU against a plain-integer reference model.
module tb_pc_alu_datapath;

  localparam int unsigned WIDTH = 16;

  logic             CLOCK = 1'b0;
  logic             PC_RESET;
  logic             PC_EN;
  logic [WIDTH-1:0] PC_IN;
  logic [WIDTH-1:0] PC_OUT;
  logic [WIDTH-1:0] SRCA;
  logic [WIDTH-1:0] SRCB;
  logic [3:0]       ALUOP;
  logic [WIDTH-1:0] ALU_OUT;
  logic             ALU_ZERO;
  logic             ALU_OVF;

  int vectors    = 0;
  int miscompares = 0;
  int unsigned model_pc;

  pc_alu_datapath #(.WIDTH(WIDTH), .PC_RESET_VAL(16'h0000)) dut (
    .CLOCK   (CLOCK),
    .PC_RESET(PC_RESET),
    .PC_EN   (PC_EN),
    .PC_IN   (PC_IN),
    .PC_OUT  (PC_OUT),
    .SRCA    (SRCA),
    .SRCB    (SRCB),
    .ALUOP   (ALUOP),
    .ALU_OUT (ALU_OUT),
    .ALU_ZERO(ALU_ZERO),
    .ALU_OVF (ALU_OVF)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU computed from the opcode definitions with signed integers.
  function automatic void ref_alu(input int unsigned op, input int unsigned a,
                                  input int unsigned b, output int unsigned r,
                                  output bit v);
    int sa, sb, s, amt;
    sa  = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb  = (b >= 32768) ? int'(b) - 65536 : int'(b);
    amt = int'(b % 16);
    v   = 1'b0;
    case (op)
      0:  begin s = sa + sb; r = unsigned'(s) & 32'hFFFF; v = (s > 32767) || (s < -32768); end
      1:  begin s = sa - sb; r = unsigned'(s) & 32'hFFFF; v = (s > 32767) || (s < -32768); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~(a | b) & 32'hFFFF;
      6:  r = (a << amt) & 32'hFFFF;
      7:  r = a >> amt;
      8:  begin s = sa >>> amt; r = unsigned'(s) & 32'hFFFF; end
      9:  r = (sa < sb) ? 1 : 0;
      10: r = (a < b) ? 1 : 0;
      11: r = a;
      12: r = b;
      default: r = 0;
    endcase
  endfunction

  task automatic alu_directed(input string tag, input logic [3:0] op,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] exp_out, input logic exp_zero,
                              input logic exp_ovf);
    ALUOP = op; SRCA = a; SRCB = b;
    #1;
    check({tag, ".out"},  32'(ALU_OUT),  32'(exp_out));
    check({tag, ".zero"}, 32'(ALU_ZERO), 32'(exp_zero));
    check({tag, ".ovf"},  32'(ALU_OVF),  32'(exp_ovf));
  endtask

  // One PC edge: drive away from the edge, model the edge, sample after it.
  task automatic pc_step(input string tag, input logic rst, input logic en,
                         input logic [15:0] din);
    @(negedge CLOCK);
    PC_RESET = rst; PC_EN = en; PC_IN = din;
    @(posedge CLOCK);
    #1;
    if (rst) model_pc = 0;
    else if (en) model_pc = din;
    check(tag, 32'(PC_OUT), model_pc);
  endtask

  initial begin
    int unsigned r_exp;
    bit          v_exp;
    logic [3:0]  rop;
    logic [15:0] ra, rb;

    PC_RESET = 1'b0; PC_EN = 1'b0; PC_IN = '0;
    SRCA = '0; SRCB = '0; ALUOP = '0;
    model_pc = 0;

    // Reset wins over enable, then hold with enable low.
    pc_step("reset_wins", 1'b1, 1'b1, 16'h1234);
    check("reset_val", 32'(PC_OUT), 32'h0000);
    pc_step("hold_after_reset", 1'b0, 1'b0, 16'h5555);

    // PC+2 loop routed through the ALU.
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLOCK);
      SRCA = PC_OUT; SRCB = 16'd2; ALUOP = 4'b0000;
      PC_RESET = 1'b0; PC_EN = 1'b1;
      #1;
      PC_IN = ALU_OUT;
      @(posedge CLOCK);
      #1;
      check($sformatf("pc_inc_%0d", i), 32'(PC_OUT), 32'(2 * i));
    end
    model_pc = 8;
    pc_step("pc_hold_8", 1'b0, 1'b0, 16'hABCD);
    pc_step("pc_reset_again", 1'b1, 1'b0, 16'hABCD);

    // Arithmetic boundaries.
    alu_directed("add_ovf",   4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    alu_directed("add_wrap",  4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    alu_directed("sub_zero",  4'b0001, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0);
    alu_directed("sub_ovf",   4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    // Logic ops.
    alu_directed("and",   4'b0010, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0);
    alu_directed("or",    4'b0011, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0);
    alu_directed("xor",   4'b0100, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0);
    alu_directed("nor",   4'b0101, 16'hF0F0, 16'h0FF0, 16'h000F, 1'b0, 1'b0);
    alu_directed("passa", 4'b1011, 16'hF0F0, 16'h0FF0, 16'hF0F0, 1'b0, 1'b0);
    alu_directed("passb", 4'b1100, 16'hF0F0, 16'h0FF0, 16'h0FF0, 1'b0, 1'b0);
    // Shifts and compares.
    alu_directed("sll_lowbits", 4'b0110, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0);
    alu_directed("srl_15",      4'b0111, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0);
    alu_directed("sra_4",       4'b1000, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0);
    alu_directed("sll_0",       4'b0110, 16'hA5C3, 16'h0010, 16'hA5C3, 1'b0, 1'b0);
    alu_directed("slt",         4'b1001, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
    alu_directed("sltu",        4'b1010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    // Undefined opcodes.
    alu_directed("undef_1110",  4'b1110, 16'h1234, 16'h8765, 16'h0000, 1'b1, 1'b0);
    alu_directed("undef_1101",  4'b1101, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0);

    // Randomized ALU against the reference model.
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ((i % 8) == 0) rb = ra;
      ALUOP = rop; SRCA = ra; SRCB = rb;
      #1;
      ref_alu(rop, ra, rb, r_exp, v_exp);
      check($sformatf("rnd_alu_out op=%0d", rop), 32'(ALU_OUT), r_exp);
      check($sformatf("rnd_alu_zero op=%0d", rop), 32'(ALU_ZERO), 32'(r_exp == 0));
      check($sformatf("rnd_alu_ovf op=%0d", rop), 32'(ALU_OVF), 32'(v_exp));
    end

    // Randomized PC traffic.
    for (int i = 0; i < 100; i++) begin
      pc_step($sformatf("rnd_pc_%0d", i), ($urandom_range(0, 9) == 0),
              1'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
